// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external 8-bit ALU between two requesters
module alu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int OP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result_out,
  output logic       zero_out,
  output logic       busy,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  input  logic       alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state, state_nxt;
  logic [3:0] cnt, len;
  logic [2:0] op_w;
  logic       last, owner, pick, fin, take;

  assign busy = state != IDLE;

  // arbitration, grants and next state; a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    pick      = (req0 & req1) ? ~last : req1;
    take      = rst_n & (state == IDLE) & (req0 | req1);
    gnt0      = take & ~pick;
    gnt1      = take & pick;
    op_w      = pick ? op1 : op0;
    len       = (op_w == 3'b100) ? 4'(MUL_CYCLES) : 4'(OP_CYCLES);
    fin       = (state == EXEC) & (cnt == 4'd1);
    state_nxt = state == IDLE ? (take ? EXEC : IDLE) :
                state == EXEC ? (fin ? RESP : EXEC) : IDLE;
  end

  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // operand capture at grant, EXEC countdown, result latch and DONE pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_select <= '0;
      result_out <= '0;
      zero_out   <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      done0 <= fin & ~owner;
      done1 <= fin & owner;
      if (fin) begin
        result_out <= alu_result;
        zero_out   <= alu_zero;
      end
      if (take) begin
        alu_data1  <= pick ? a1 : a0;
        alu_data2  <= pick ? b1 : b0;
        alu_select <= op_w;
        owner      <= pick;
        last       <= pick;
        cnt        <= len;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_CYCLES, default 2, sets the EXEC cycles spent on a multiply (SELECT 100); legal range 1..15.
REQ-002 Parameter OP_CYCLES, default 1, sets the EXEC cycles spent on every non-multiply opcode; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 REQ0, REQ1  input  1 each  requester operation request; held high until the matching GNT.
REQ-006 OP0, OP1  input  3 each  requested ALU opcode (000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL).
REQ-007 A0, B0, A1, B1  input  8 each  requester operands (A maps to DATA1, B to DATA2).
REQ-008 GNT0, GNT1  output  1 each  combinational one-cycle grant; operands are captured at the edge ending that cycle.
REQ-009 DONE0, DONE1  output  1 each  registered one-cycle completion pulse to the granted requester.
REQ-010 RESULT_OUT  output  8  registered result of the last completed operation.
REQ-011 ZERO_OUT  output  1  registered ALU ZERO flag of the last completed operation.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 ALU_DATA1, ALU_DATA2  output  8 each  registered operands driven to the shared 8-bit ALU.
REQ-014 ALU_SELECT  output  3  registered opcode driven to the shared ALU.
REQ-015 ALU_RESULT  input  8  shared ALU result.
REQ-016 ALU_ZERO  input  1  shared ALU zero flag.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-018 IDLE SHALL assert exactly one GNT when any REQ is high, load ALU_DATA1/ALU_DATA2/ALU_SELECT from the winner, load the cycle counter and move to EXEC.
REQ-019 If REQ0 and REQ1 are both high, the requester not granted last SHALL win; after reset requester 0 is treated as the least recently granted.
REQ-020 A single active requester SHALL be granted regardless of the round-robin pointer.
REQ-021 EXEC SHALL last MUL_CYCLES cycles for opcode 100 and OP_CYCLES cycles for all other opcodes, including 101-111.
REQ-022 On the last EXEC cycle, ALU_RESULT and ALU_ZERO SHALL be registered into RESULT_OUT and ZERO_OUT, and the FSM SHALL move to RESP.
REQ-023 RESP SHALL assert DONE of the granted requester for exactly one cycle and then return to IDLE.
REQ-024 With GNT in cycle T, DONE SHALL be high in cycle T+1+N, where N is the EXEC length; no new GNT is issued before cycle T+N+2.
REQ-025 GNT SHALL never be asserted outside IDLE.
REQ-026 REQ and operand changes after GNT SHALL NOT affect the operation in flight.
REQ-027 A REQ withdrawn before its GNT SHALL be dropped silently.
REQ-028 RESULT_OUT and ZERO_OUT SHALL hold their value until the next completion.
REQ-029 ALU_DATA1, ALU_DATA2 and ALU_SELECT SHALL remain stable for the whole of EXEC.
REQ-030 Undefined opcodes (101-111) SHALL complete normally and return whatever the ALU produces (0 and ZERO=1 with the standard ALU).

Reset
REQ-031 While RESET is low, the FSM SHALL be in IDLE and the round-robin pointer SHALL be at 1 (last granted = 1).
REQ-032 While RESET is low, all registered outputs SHALL be 0: RESULT_OUT, ALU_DATA1, ALU_DATA2 and ALU_SELECT = 8'h00/3'b000, and ZERO_OUT, DONE0, DONE1 and BUSY = 0.
REQ-033 While RESET is low, GNT0 and GNT1 SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL abort it immediately with no DONE pulse; the aborted requester must re-request.

Verification
REQ-035 Reset release; REQ0=1, OP0=001, A0=8'd5, B0=8'd3 -> GNT0 in cycle T, DONE0 in cycle T+2, RESULT_OUT=8'd8, ZERO_OUT=0.
REQ-036 REQ0 and REQ1 held high continuously for 4 operations -> grants alternate 0,1,0,1, with no overlapping DONE pulses.
REQ-037 OP1=100, A1=8'd6, B1=8'd7, MUL_CYCLES=2 -> DONE1 in cycle T+3, RESULT_OUT=8'd42.
REQ-038 OP0=010, A0=8'hF0, B0=8'h0F -> RESULT_OUT=8'h00, ZERO_OUT=1; then OP0=110 -> RESULT_OUT=8'h00, ZERO_OUT=1, DONE0 pulses.
REQ-039 RESET driven low during EXEC of a multiply -> no DONE pulse, all outputs 0 asynchronously, IDLE after release, next grant goes to requester 0.
REQ-040 A0 changed from 8'd1 to 8'd9 one cycle after GNT0 with OP0=000, B0=8'd1 -> RESULT_OUT=8'd1.
